led_7seg_decode: RTL and testbench

LED_7SEG_DECODE -- requirements
Module: led_7seg_decode

---
 rtl/led_7seg_decode.sv | 194 +++++++++++++++++++
 tb/tb_led_7seg_decode.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_7seg_decode.sv
// -----------------------------------------------------------------------------
// led_7seg_decode
//
// Recovers a 3-digit value from three 7-segment displays. The segment lines
// come from another device and can glitch while digits are being updated. A
// word is accepted only after every segment line has been stable for
// STABLE_CYCLES consecutive synchronized samples.
//
// Parameters
//   STABLE_CYCLES : consecutive unchanged synchronized samples needed before a
//                   word is accepted (2..65535)
//
// Ports
//   clk        : system clock; all state updates on its rising edge
//   rst        : asynchronous active-high reset
//   seg_H      : high digit segments, bit 0 = a .. bit 6 = g, active-low
//   seg_M      : middle digit segments, same format
//   seg_L      : low digit segments, same format
//   Data_out   : last accepted word, {H, M, L} as hex nibbles
//   data_valid : one-cycle strobe when a newly accepted word differs from the
//                previous one (or is the first lock after reset)
//   locked     : current inputs are stable, valid and shown on Data_out
//   seg_err    : current stable inputs contain an undecodable digit
//   err_mask   : undecodable digits, bit 2 = H, bit 1 = M, bit 0 = L
// -----------------------------------------------------------------------------
module led_7seg_decode #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_H,
    input  logic [6:0]  seg_M,
    input  logic [6:0]  seg_L,
    output logic [11:0] Data_out,
    output logic        data_valid,
    output logic        locked,
    output logic        seg_err,
    output logic [2:0]  err_mask
);

    localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    // Returns {valid, nibble}. The case items are written in the order
    // {a, b, c, d, e, f, g}, i.e. the port vector read from bit 0 upwards.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg);
        logic [6:0] code;
        logic [4:0] res;
        code = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6]};
        case (code)
            7'b0000001: res = {1'b1, 4'h0};
            7'b1001111: res = {1'b1, 4'h1};
            7'b0010010: res = {1'b1, 4'h2};
            7'b0000110: res = {1'b1, 4'h3};
            7'b1001100: res = {1'b1, 4'h4};
            7'b0100100: res = {1'b1, 4'h5};
            7'b0100000: res = {1'b1, 4'h6};
            7'b0001111: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0001100: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b1100000: res = {1'b1, 4'hB};
            7'b0110001: res = {1'b1, 4'hC};
            7'b1000010: res = {1'b1, 4'hD};
            7'b0110000: res = {1'b1, 4'hE};
            7'b0111000: res = {1'b1, 4'hF};
            default:    res = {1'b0, 4'h0};   // includes blank 1111111
        endcase
        return res;
    endfunction

    // All 21 lines packed as {H, M, L}; digit gi occupies bits [gi*7 +: 7].
    logic [20:0] seg_raw;
    logic [20:0] s1_reg;
    logic [20:0] s2_reg;
    logic [20:0] prev_reg;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    state_t      state_reg;
    state_t      state_next;
    logic        first_lock_reg;
    logic        first_lock_next;
    logic [11:0] data_out_reg;
    logic [11:0] data_out_next;
    logic        data_valid_reg;
    logic        data_valid_next;
    logic [2:0]  err_mask_reg;
    logic [2:0]  err_mask_next;

    logic [11:0] word_dec;
    logic [2:0]  dig_ok;
    logic        same;
    logic        accept;

    assign seg_raw = {seg_H, seg_M, seg_L};

    // Per-digit decoders on the synchronized sample.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dec
            assign {dig_ok[gi], word_dec[gi*4 +: 4]} = decode_digit(s2_reg[gi*7 +: 7]);
        end
    endgenerate

    assign same   = (s2_reg == prev_reg);
    assign accept = same && (cnt_reg == CNT_MAX);

    // Stability counter: clears on any change, saturates at CNT_MAX.
    always_comb begin
        cnt_next = cnt_reg;
        if (!same) begin
            cnt_next = 16'd0;
        end else if (cnt_reg < CNT_MAX) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    // Acceptance state machine.
    always_comb begin
        state_next      = state_reg;
        first_lock_next = first_lock_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        err_mask_next   = err_mask_reg;
        case (state_reg)
            ST_SETTLE: begin
                if (accept) begin
                    if (&dig_ok) begin
                        state_next      = ST_LOCKED;
                        data_out_next   = word_dec;
                        // An identical relock after a glitch is not news,
                        // except for the very first lock after reset.
                        data_valid_next = first_lock_reg || (word_dec != data_out_reg);
                        first_lock_next = 1'b0;
                    end else begin
                        state_next    = ST_FAULT;
                        err_mask_next = ~dig_ok;
                    end
                end
            end
            ST_LOCKED: begin
                if (!same) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_FAULT: begin
                if (!same) begin
                    state_next    = ST_SETTLE;
                    err_mask_next = 3'b000;
                end
            end
            default: begin
                state_next    = ST_SETTLE;
                err_mask_next = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg         <= '1;
            s2_reg         <= '1;
            prev_reg       <= '1;
            cnt_reg        <= 16'd0;
            state_reg      <= ST_SETTLE;
            first_lock_reg <= 1'b1;
            data_out_reg   <= 12'h000;
            data_valid_reg <= 1'b0;
            err_mask_reg   <= 3'b000;
        end else begin
            s1_reg         <= seg_raw;
            s2_reg         <= s1_reg;
            prev_reg       <= s2_reg;
            cnt_reg        <= cnt_next;
            state_reg      <= state_next;
            first_lock_reg <= first_lock_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            err_mask_reg   <= err_mask_next;
        end
    end

    assign Data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign err_mask   = err_mask_reg;
    assign locked     = (state_reg == ST_LOCKED);
    assign seg_err    = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_led_7seg_decode.sv
// -----------------------------------------------------------------------------
// tb_led_7seg_decode
//
// Directed bench for led_7seg_decode. One instance uses the default
// STABLE_CYCLES=16, a second uses the minimum STABLE_CYCLES=2; both share the
// stimulus. Inputs change just after a rising edge, so the next rising edge
// is "edge 1"; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_led_7seg_decode;

    // Port values (bit 0 = a .. bit 6 = g, active-low) for each digit.
    localparam logic [6:0] C0 = 7'h40;
    localparam logic [6:0] C1 = 7'h79;
    localparam logic [6:0] C2 = 7'h24;
    localparam logic [6:0] C3 = 7'h30;
    localparam logic [6:0] C4 = 7'h19;
    localparam logic [6:0] C5 = 7'h12;
    localparam logic [6:0] C6 = 7'h02;
    localparam logic [6:0] C7 = 7'h78;
    localparam logic [6:0] C8 = 7'h00;
    localparam logic [6:0] C9 = 7'h18;
    localparam logic [6:0] CA = 7'h08;
    localparam logic [6:0] CB = 7'h03;
    localparam logic [6:0] CC = 7'h46;
    localparam logic [6:0] BLANK = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg_H = BLANK;
    logic [6:0]  seg_M = BLANK;
    logic [6:0]  seg_L = BLANK;

    logic [11:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        seg_err;
    logic [2:0]  err_mask;

    logic [11:0] d2_data_out;
    logic        d2_data_valid;
    logic        d2_locked;
    logic        d2_seg_err;
    logic [2:0]  d2_err_mask;

    int checks   = 0;
    int failures = 0;

    led_7seg_decode #(.STABLE_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_H      (seg_H),
        .seg_M      (seg_M),
        .seg_L      (seg_L),
        .Data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .seg_err    (seg_err),
        .err_mask   (err_mask)
    );

    led_7seg_decode #(.STABLE_CYCLES(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .seg_H      (seg_H),
        .seg_M      (seg_M),
        .seg_L      (seg_L),
        .Data_out   (d2_data_out),
        .data_valid (d2_data_valid),
        .locked     (d2_locked),
        .seg_err    (d2_seg_err),
        .err_mask   (d2_err_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        seg_H = BLANK;
        seg_M = BLANK;
        seg_L = BLANK;
        step();
        step();
        rst   = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, locked, seg_err, err_mask} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {data_out, data_valid, locked, seg_err, err_mask});
        end
        checks++;
        if ({d2_data_out, d2_data_valid, d2_locked, d2_seg_err, d2_err_mask} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs_min got=%h required=0", {d2_data_out, d2_data_valid, d2_locked, d2_seg_err, d2_err_mask});
        end
        step();
        step();
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_first_lock;
        do_reset();
        seg_H = C1; seg_M = C2; seg_L = C3;
        for (int e = 1; e <= 18; e++) begin
            step();
            checks++;
            if (data_valid !== 1'b0 || locked !== 1'b0) begin
                failures++;
                $display("FAIL first_lock_early edge=%0d data_valid=%b locked=%b required 0 0", e, data_valid, locked);
            end
        end
        step();
        checks++;
        if (data_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_lock_dv edge=19 got=%b required=1", data_valid);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL first_lock_locked edge=19 got=%b required=1", locked);
        end
        checks++;
        if (data_out !== 12'h123) begin
            failures++;
            $display("FAIL first_lock_data got=%h required=123", data_out);
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL first_lock_pulse_end data_valid=%b locked=%b required 0 1", data_valid, locked);
        end
        $display("test_first_lock done data_out=%h", data_out);
    endtask

    task automatic test_glitch;
        seg_L = C8;
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (locked !== (e < 3) || data_valid !== 1'b0) begin
                failures++;
                $display("FAIL glitch_drop edge=%0d locked=%b data_valid=%b required locked=%b dv=0", e, locked, data_valid, (e < 3));
            end
        end
        seg_L = C3;
        for (int e = 1; e <= 18; e++) begin
            step();
            checks++;
            if (data_valid !== 1'b0 || locked !== 1'b0) begin
                failures++;
                $display("FAIL glitch_settle edge=%0d data_valid=%b locked=%b required 0 0", e, data_valid, locked);
            end
        end
        step();
        checks++;
        if (locked !== 1'b1 || data_valid !== 1'b0 || data_out !== 12'h123) begin
            failures++;
            $display("FAIL glitch_relock locked=%b data_valid=%b data_out=%h required 1 0 123", locked, data_valid, data_out);
        end
        $display("test_glitch done data_out=%h", data_out);
    endtask

    task automatic test_invalid_digit;
        seg_M = BLANK;
        for (int e = 1; e <= 18; e++) begin
            step();
            checks++;
            if (data_valid !== 1'b0 || seg_err !== 1'b0 || err_mask !== 3'b000) begin
                failures++;
                $display("FAIL invalid_settle edge=%0d dv=%b seg_err=%b err_mask=%b required 0 0 000", e, data_valid, seg_err, err_mask);
            end
        end
        step();
        checks++;
        if (seg_err !== 1'b1 || err_mask !== 3'b010) begin
            failures++;
            $display("FAIL invalid_fault seg_err=%b err_mask=%b required 1 010", seg_err, err_mask);
        end
        checks++;
        if (locked !== 1'b0 || data_valid !== 1'b0 || data_out !== 12'h123) begin
            failures++;
            $display("FAIL invalid_outputs locked=%b dv=%b data_out=%h required 0 0 123", locked, data_valid, data_out);
        end
        step();
        checks++;
        if (seg_err !== 1'b1 || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_hold seg_err=%b dv=%b required 1 0", seg_err, data_valid);
        end
        $display("test_invalid_digit done err_mask=%b", err_mask);
    endtask

    task automatic test_new_word;
        seg_H = CA; seg_M = CB; seg_L = CC;
        step();
        step();
        checks++;
        if (seg_err !== 1'b1) begin
            failures++;
            $display("FAIL new_word_fault_hold edge=2 seg_err=%b required 1", seg_err);
        end
        step();
        checks++;
        if (seg_err !== 1'b0 || err_mask !== 3'b000 || data_out !== 12'h123) begin
            failures++;
            $display("FAIL new_word_leave_fault seg_err=%b err_mask=%b data_out=%h required 0 000 123", seg_err, err_mask, data_out);
        end
        for (int e = 4; e <= 18; e++) begin
            step();
            checks++;
            if (data_valid !== 1'b0) begin
                failures++;
                $display("FAIL new_word_early_dv edge=%0d got=%b required=0", e, data_valid);
            end
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || locked !== 1'b1 || data_out !== 12'hABC) begin
            failures++;
            $display("FAIL new_word_lock dv=%b locked=%b data_out=%h required 1 1 abc", data_valid, locked, data_out);
        end
        step();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL new_word_pulse_end dv=%b required 0", data_valid);
        end
        $display("test_new_word done data_out=%h", data_out);
    endtask

    // 456 changes to 789 just before edge 17, so the synchronized change lands
    // exactly on the edge that would otherwise have accepted 456.
    task automatic test_restart;
        seg_H = C4; seg_M = C5; seg_L = C6;
        for (int e = 1; e <= 34; e++) begin
            step();
            if (e == 16) begin
                seg_H = C7; seg_M = C8; seg_L = C9;
            end
            checks++;
            if (data_valid !== 1'b0 || (e >= 3 && locked !== 1'b0)) begin
                failures++;
                $display("FAIL restart_no_lock edge=%0d dv=%b locked=%b data_out=%h", e, data_valid, locked, data_out);
            end
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || locked !== 1'b1 || data_out !== 12'h789) begin
            failures++;
            $display("FAIL restart_lock dv=%b locked=%b data_out=%h required 1 1 789", data_valid, locked, data_out);
        end
        $display("test_restart done data_out=%h", data_out);
    endtask

    task automatic test_async_reset;
        seg_H = C4; seg_M = C5; seg_L = C6;
        for (int e = 1; e <= 8; e++) begin
            step();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, locked, seg_err, err_mask} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h required=0", {data_out, data_valid, locked, seg_err, err_mask});
        end
        step();
        rst = 1'b0;
        seg_H = C1; seg_M = C2; seg_L = C3;
        for (int e = 1; e <= 18; e++) begin
            step();
            checks++;
            if (data_valid !== 1'b0 || data_out !== 12'h000) begin
                failures++;
                $display("FAIL async_reset_settle edge=%0d dv=%b data_out=%h required 0 000", e, data_valid, data_out);
            end
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || locked !== 1'b1 || data_out !== 12'h123) begin
            failures++;
            $display("FAIL async_reset_relock dv=%b locked=%b data_out=%h required 1 1 123", data_valid, locked, data_out);
        end
        $display("test_async_reset done data_out=%h", data_out);
    endtask

    // Word 000 equals the reset value of Data_out, so only the first-lock
    // flag can make data_valid pulse here.
    task automatic test_first_lock_zero;
        do_reset();
        seg_H = C0; seg_M = C0; seg_L = C0;
        for (int e = 1; e <= 18; e++) begin
            step();
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL zero_early_lock edge=18 locked=%b required 0", locked);
        end
        step();
        checks++;
        if (data_valid !== 1'b1 || locked !== 1'b1 || data_out !== 12'h000) begin
            failures++;
            $display("FAIL zero_first_lock dv=%b locked=%b data_out=%h required 1 1 000", data_valid, locked, data_out);
        end
        $display("test_first_lock_zero done data_out=%h", data_out);
    endtask

    task automatic test_min_param;
        do_reset();
        seg_H = C1; seg_M = C2; seg_L = C3;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (d2_data_valid !== 1'b0 || d2_locked !== 1'b0) begin
                failures++;
                $display("FAIL min_param_early edge=%0d dv=%b locked=%b required 0 0", e, d2_data_valid, d2_locked);
            end
        end
        step();
        checks++;
        if (d2_data_valid !== 1'b1 || d2_locked !== 1'b1 || d2_data_out !== 12'h123) begin
            failures++;
            $display("FAIL min_param_lock edge=5 dv=%b locked=%b data_out=%h required 1 1 123", d2_data_valid, d2_locked, d2_data_out);
        end
        step();
        checks++;
        if (d2_data_valid !== 1'b0 || d2_locked !== 1'b1) begin
            failures++;
            $display("FAIL min_param_pulse_end dv=%b locked=%b required 0 1", d2_data_valid, d2_locked);
        end
        $display("test_min_param done data_out=%h", d2_data_out);
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_glitch();
        test_invalid_digit();
        test_new_word();
        test_restart();
        test_async_reset();
        test_first_lock_zero();
        test_min_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
